// File: rtl/deserializer_unit_cell_16_if.sv
// Bundle of the serial input and parallel/status outputs.
// master drives SERIAL_IN; slave is the deserializer side.
interface deserializer_unit_cell_16_if;
    logic        SERIAL_IN;
    logic [15:0] PAR_OUT;
    logic        PAR_VALID;
    logic        LOCKED;
    logic        SYNC_SEEN;
    logic [7:0]  ERR_COUNT;

    modport master (
        output SERIAL_IN,
        input  PAR_OUT,
        input  PAR_VALID,
        input  LOCKED,
        input  SYNC_SEEN,
        input  ERR_COUNT
    );

    modport slave (
        input  SERIAL_IN,
        output PAR_OUT,
        output PAR_VALID,
        output LOCKED,
        output SYNC_SEEN,
        output ERR_COUNT
    );
endinterface

// File: rtl/deserializer_unit_cell_16.sv
// Serial-to-parallel receiver with sync-word alignment and lock timeout.
// Optional lock-loss counter: define DESER_ERR_CNT_EN.
module deserializer_unit_cell_16 #(
    parameter logic [15:0] SYNC_WORD    = 16'hC5AF,
    parameter int unsigned LOCK_TIMEOUT = 32
) (
    input  logic                          CLK,
    input  logic                          RESET,
    deserializer_unit_cell_16_if.slave    bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] TO_W = LOCK_TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [7:0]  word_inc;
    logic [15:0] par_out_q, par_out_d;
    logic        par_valid_q, par_valid_d;
    logic        sync_seen_q, sync_seen_d;
    logic [15:0] w;
    logic        is_sync;
`ifdef DESER_ERR_CNT_EN
    logic [7:0]  err_q, err_d;
`endif

    assign w        = {sr_q[14:0], bus.SERIAL_IN};
    assign is_sync  = (w == SYNC_WORD);
    assign word_inc = word_cnt_q + 8'd1;

    // State register and all output registers, synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            sync_seen_q <= 1'b0;
`ifdef DESER_ERR_CNT_EN
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            sync_seen_q <= sync_seen_d;
`ifdef DESER_ERR_CNT_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state: hunt for sync, then frame words every 16 bits
    always_comb begin
        state_d     = state_q;
        sr_d        = w;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        sync_seen_d = 1'b0;
`ifdef DESER_ERR_CNT_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            HUNT: begin
                if (is_sync) begin
                    state_d     = LOCKED;
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                    sync_seen_d = 1'b1;
                end
            end
            LOCKED: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    if (is_sync) begin
                        sync_seen_d = 1'b1;
                        word_cnt_d  = '0;
                    end else begin
                        par_out_d   = w;
                        par_valid_d = 1'b1;
                        word_cnt_d  = word_inc;
                        // Last unsynced word is still delivered
                        if (word_inc == TO_W) begin
                            state_d = HUNT;
`ifdef DESER_ERR_CNT_EN
                            if (err_q != 8'hFF)
                                err_d = err_q + 8'd1;
`endif
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign bus.PAR_OUT   = par_out_q;
    assign bus.PAR_VALID = par_valid_q;
    assign bus.LOCKED    = (state_q == LOCKED);
    assign bus.SYNC_SEEN = sync_seen_q;
`ifdef DESER_ERR_CNT_EN
    assign bus.ERR_COUNT = err_q;
`else
    assign bus.ERR_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_deserializer_unit_cell_16.sv
// Directed bench for deserializer_unit_cell_16.
// Three instances with LOCK_TIMEOUT 32, 3 and 1 share one serial stream.
module tb_deserializer_unit_cell_16;

    logic CLK;
    logic RESET;

    deserializer_unit_cell_16_if if32 ();
    deserializer_unit_cell_16_if if3 ();
    deserializer_unit_cell_16_if if1 ();

    deserializer_unit_cell_16 #(.LOCK_TIMEOUT(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .bus(if32.slave));
    deserializer_unit_cell_16 #(.LOCK_TIMEOUT(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .bus(if3.slave));
    deserializer_unit_cell_16 #(.LOCK_TIMEOUT(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(if1.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt32  = 0;
    int vcnt3   = 0;
    int both_hi = 0;

`ifdef DESER_ERR_CNT_EN
    localparam logic [7:0] EXP_ERR1   = 8'd1;
    localparam logic [7:0] EXP_ERRSAT = 8'd255;
`else
    localparam logic [7:0] EXP_ERR1   = 8'd0;
    localparam logic [7:0] EXP_ERRSAT = 8'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tally();
        if (if32.PAR_VALID === 1'b1) vcnt32++;
        if (if3.PAR_VALID === 1'b1) vcnt3++;
        if (if32.PAR_VALID && if32.SYNC_SEEN) both_hi++;
        if (if3.PAR_VALID && if3.SYNC_SEEN) both_hi++;
        if (if1.PAR_VALID && if1.SYNC_SEEN) both_hi++;
    endtask

    task automatic send_bit(input logic b);
        if32.SERIAL_IN = b;
        if3.SERIAL_IN  = b;
        if1.SERIAL_IN  = b;
        @(posedge CLK);
        #1;
        tally();
    endtask

    task automatic send_word(input logic [15:0] wd);
        for (int i = 15; i >= 0; i--) send_bit(wd[i]);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        vcnt32 = 0;
        vcnt3  = 0;
    endtask

    logic [15:0] rw;

    initial begin
        RESET = 1'b0;
        if32.SERIAL_IN = 1'b0;
        if3.SERIAL_IN  = 1'b0;
        if1.SERIAL_IN  = 1'b0;
        #2;

        // Reset state and basic sync + one word
        do_reset();
        check("rst_par_out", if32.PAR_OUT, 16'h0000);
        check("rst_valid", if32.PAR_VALID, 1'b0);
        check("rst_locked", if32.LOCKED, 1'b0);
        check("rst_sync", if32.SYNC_SEEN, 1'b0);
        check("rst_err", if32.ERR_COUNT, 8'h00);
        send_word(16'hC5AF);
        check("p1_sync_seen", if32.SYNC_SEEN, 1'b1);
        check("p1_locked", if32.LOCKED, 1'b1);
        send_word(16'h1234);
        check("p1_valid", if32.PAR_VALID, 1'b1);
        check("p1_data", if32.PAR_OUT, 16'h1234);
        check("p1_vcnt", vcnt32, 1);
        send_bit(1'b0);
        check("p1_valid_drop", if32.PAR_VALID, 1'b0);
        check("p1_hold", if32.PAR_OUT, 16'h1234);
        check("p1_sync_drop", if32.SYNC_SEEN, 1'b0);

        // Junk bits then sync and three words
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("p2_no_lock", if32.LOCKED, 1'b0);
        send_word(16'hC5AF);
        check("p2_sync", if32.SYNC_SEEN, 1'b1);
        send_word(16'hA5A5);
        check("p2_w0", if32.PAR_OUT, 16'hA5A5);
        check("p2_v0", if32.PAR_VALID, 1'b1);
        send_word(16'h0000);
        check("p2_w1", if32.PAR_OUT, 16'h0000);
        check("p2_v1", if32.PAR_VALID, 1'b1);
        send_word(16'hFFFF);
        check("p2_w2", if32.PAR_OUT, 16'hFFFF);
        check("p2_v2", if32.PAR_VALID, 1'b1);
        check("p2_vcnt", vcnt32, 3);

        // Timeout with LOCK_TIMEOUT = 3
        do_reset();
        send_word(16'hC5AF);
        send_word(16'h1111);
        check("p3_lock1", if3.LOCKED, 1'b1);
        send_word(16'h2222);
        check("p3_lock2", if3.LOCKED, 1'b1);
        send_word(16'h3333);
        check("p3_valid3", if3.PAR_VALID, 1'b1);
        check("p3_data3", if3.PAR_OUT, 16'h3333);
        check("p3_unlock", if3.LOCKED, 1'b0);
        check("p3_err", if3.ERR_COUNT, EXP_ERR1);
        check("p3_vcnt", vcnt3, 3);

        // Mid-stream sync resets the word count
        do_reset();
        send_word(16'hC5AF);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'hC5AF);
        check("p4_resync", if3.SYNC_SEEN, 1'b1);
        check("p4_no_valid", if3.PAR_VALID, 1'b0);
        send_word(16'h3333);
        send_word(16'h4444);
        check("p4_locked", if3.LOCKED, 1'b1);
        check("p4_data", if3.PAR_OUT, 16'h4444);
        check("p4_vcnt", vcnt3, 4);
        check("p4_err", if3.ERR_COUNT, 8'h00);

        // Reset in the middle of a locked word
        do_reset();
        send_word(16'hC5AF);
        send_word(16'h1234);
        rw = 16'hABCD;
        for (int i = 15; i >= 9; i--) send_bit(rw[i]);
        if32.SERIAL_IN = 1'b1;
        if3.SERIAL_IN  = 1'b1;
        if1.SERIAL_IN  = 1'b1;
        do_reset();
        check("p5_par_out", if32.PAR_OUT, 16'h0000);
        check("p5_locked", if32.LOCKED, 1'b0);
        check("p5_valid", if32.PAR_VALID, 1'b0);
        check("p5_sync", if32.SYNC_SEEN, 1'b0);
        for (int i = 8; i >= 0; i--) send_bit(rw[i]);
        check("p5_no_strobe", vcnt32, 0);
        send_word(16'hC5AF);
        check("p5_relock_sync", if32.SYNC_SEEN, 1'b1);
        check("p5_relock", if32.LOCKED, 1'b1);

        // LOCK_TIMEOUT = 1: every sync+data pair loses lock once
        do_reset();
        send_word(16'hC5AF);
        send_word(16'h0000);
        check("p6_first_loss", if1.ERR_COUNT, EXP_ERR1);
        check("p6_unlocked", if1.LOCKED, 1'b0);
        for (int p = 1; p < 300; p++) begin
            send_word(16'hC5AF);
            send_word(16'h0000);
        end
        check("p6_err_sat", if1.ERR_COUNT, EXP_ERRSAT);
        check("p6_final_unlock", if1.LOCKED, 1'b0);

        check("never_both_strobes", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
